// File: rtl/seven_seg_scanner.sv
//------------------------------------------------------------------------------
// seven_seg_scanner
//
// Purpose:
//   Time-multiplexes four BCD digits onto a common-anode 4-digit 7-segment
//   display. A prescaler divides clk into digit slots of REFRESH_DIV cycles.
//   Each slot opens with BLANK_CYCLES of anode-off guard time to avoid
//   ghosting. Input digits, decimal points and the leading-zero flag are
//   captured once per 4-slot frame so a frame always shows one coherent value.
//
// Parameters:
//   REFRESH_DIV  - clk cycles per digit slot (4 .. 2^20)
//   BLANK_CYCLES - anode-off guard cycles at the start of each slot
//                  (1 .. REFRESH_DIV-2)
//
// Ports:
//   clk       in   single clock, all state on its rising edge
//   grst      in   asynchronous active-low reset
//   bcd_in    in   [15:0] four BCD digits, [3:0] = rightmost digit
//   dp_in     in   [3:0]  decimal point request per digit, active-high
//   blank_lz  in   blank leading zeros when 1
//   disp_en   in   when 0 all anodes are off, scanning keeps running
//   an        out  [3:0] anode drive, active-low, one-hot-low when lit
//   seg       out  [6:0] cathodes, active-low, seg[0]=CA .. seg[6]=CG
//   dp        out  decimal-point cathode, active-low
//   digit_idx out  [1:0] index of the current slot
//------------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        grst,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic        disp_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_idx
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(BLANK_CYCLES);

    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_next;
    logic [1:0]    idx_next;
    logic          slot_wrap;
    logic          frame_end;

    logic [15:0]   snap_bcd;
    logic [3:0]    snap_dp;
    logic          snap_lz;

    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    logic [3:0]    cur_digit;
    logic          cur_blank;
    logic          lead3_zero;
    logic          lead2_zero;
    logic          lead1_zero;

    // 7-segment font, active-low, bit order {CG,CF,CE,CD,CC,CB,CA}.
    // Non-BCD codes show a dash so a broken counter chain is visible.
    function automatic logic [6:0] decode_digit(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b0111111;
        endcase
        return pattern;
    endfunction

    assign slot_wrap = (prescaler == PRESC_LAST);
    assign frame_end = slot_wrap && (digit_idx == 2'd3);

    // State register: the prescaler and the slot index. digit_idx is the
    // scan state itself and is driven straight onto the output port.
    always_ff @(posedge clk or negedge grst) begin
        if (!grst) begin
            prescaler <= '0;
            digit_idx <= 2'd0;
        end else begin
            prescaler <= prescaler_next;
            digit_idx <= idx_next;
        end
    end

    // Next-state logic: the slot index only moves when the prescaler wraps.
    always_comb begin
        prescaler_next = prescaler + 1'b1;
        idx_next       = digit_idx;
        if (slot_wrap) begin
            prescaler_next = '0;
            idx_next       = digit_idx + 2'd1;
        end
    end

    // Frame snapshot. Captured on the last cycle of slot 3 so the value used
    // for slot 3's outputs is still the old one and slot 0 of the next frame
    // starts on the new one.
    always_ff @(posedge clk or negedge grst) begin
        if (!grst) begin
            snap_bcd <= '0;
            snap_dp  <= '0;
            snap_lz  <= 1'b0;
        end else if (frame_end) begin
            snap_bcd <= bcd_in;
            snap_dp  <= dp_in;
            snap_lz  <= blank_lz;
        end
    end

    // Leading-zero chain: a digit is a leading zero when it and every digit
    // to its left are zero. Digit 0 always shows.
    always_comb begin
        lead3_zero = (snap_bcd[15:12] == 4'd0);
        lead2_zero = lead3_zero && (snap_bcd[11:8] == 4'd0);
        lead1_zero = lead2_zero && (snap_bcd[7:4] == 4'd0);
    end

    // Output logic: everything the display needs for this cycle's slot,
    // computed from the same prescaler/digit_idx so that anode and cathode
    // patterns always switch together when registered.
    always_comb begin
        cur_digit = snap_bcd[3:0];
        cur_blank = 1'b0;
        case (digit_idx)
            2'd0: begin
                cur_digit = snap_bcd[3:0];
                cur_blank = 1'b0;
            end
            2'd1: begin
                cur_digit = snap_bcd[7:4];
                cur_blank = snap_lz && lead1_zero;
            end
            2'd2: begin
                cur_digit = snap_bcd[11:8];
                cur_blank = snap_lz && lead2_zero;
            end
            default: begin
                cur_digit = snap_bcd[15:12];
                cur_blank = snap_lz && lead3_zero;
            end
        endcase

        seg_next = cur_blank ? 7'b1111111 : decode_digit(cur_digit);
        dp_next  = ~snap_dp[digit_idx];

        if (!disp_en || (prescaler < GUARD_END)) begin
            an_next = 4'b1111;
        end else begin
            an_next = ~(4'b0001 << digit_idx);
        end
    end

    // Registered display drive; reset forces every segment and anode dark
    // without waiting for a clock edge.
    always_ff @(posedge clk or negedge grst) begin
        if (!grst) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
//------------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Purpose:
//   Self-checking bench for seven_seg_scanner with REFRESH_DIV=8 and
//   BLANK_CYCLES=2. A reference model works from the elapsed cycle count
//   since reset release: slot and prescaler positions are derived by
//   division, the frame snapshot is taken every 4*REFRESH_DIV cycles, and
//   digits are decoded from a lookup table. Each clock edge pushes the
//   expected display state into a queue; a monitor pops and compares it
//   shortly after the edge.
//------------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * RD;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
    } expect_t;

    logic        clk = 1'b0;
    logic        grst = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic        disp_en = 1'b1;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;

    expect_t     exp_q[$];
    int          tests = 0;
    int          fails = 0;

    int          n_cyc = 0;
    logic [15:0] snap_bcd = '0;
    logic [3:0]  snap_dp = '0;
    logic        snap_lz = 1'b0;
    logic [6:0]  font [16];

    seven_seg_scanner #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk       (clk),
        .grst      (grst),
        .bcd_in    (bcd_in),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .disp_en   (disp_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    // Single field comparison with a FAIL line on mismatch.
    task automatic check_field(input string name, input logic [6:0] act,
                               input logic [6:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    task automatic check_output(input expect_t e);
        check_field("an",        {3'b000, an},        {3'b000, e.an});
        check_field("seg",       seg,                 e.seg);
        check_field("dp",        {6'b0, dp},          {6'b0, e.dp});
        check_field("digit_idx", {5'b0, digit_idx},   {5'b0, e.idx});
    endtask

    task automatic check_reset_state();
        check_field("rst_an",        {3'b000, an},      7'b0001111);
        check_field("rst_seg",       seg,               7'b1111111);
        check_field("rst_dp",        {6'b0, dp},        7'b0000001);
        check_field("rst_digit_idx", {5'b0, digit_idx}, 7'b0000000);
    endtask

    // Expected cathodes for digit position d from the current snapshot.
    // A position is a leading zero when the whole value from that position
    // upward is zero.
    function automatic logic [6:0] model_seg(input int d);
        logic [15:0] upper;
        logic [3:0]  value;
        upper = snap_bcd >> (4 * d);
        value = upper[3:0];
        if (snap_lz && d != 0 && upper == 16'd0) return 7'b1111111;
        return font[value];
    endfunction

    // Reference model: one expected display state per clock edge.
    initial begin
        forever begin
            @(posedge clk or negedge grst);
            if (!grst) begin
                n_cyc    = 0;
                snap_bcd = '0;
                snap_dp  = '0;
                snap_lz  = 1'b0;
                exp_q.delete();
            end else begin
                expect_t e;
                int      p;
                int      d;
                logic [3:0] onehot;
                p      = n_cyc % RD;
                d      = (n_cyc / RD) % 4;
                onehot = 4'b0001 << d;
                e.an   = (!disp_en || p < BC) ? 4'b1111 : ~onehot;
                e.seg  = model_seg(d);
                e.dp   = ~snap_dp[d];
                e.idx  = 2'((n_cyc + 1) / RD % 4);
                exp_q.push_back(e);
                if (n_cyc % FRAME == FRAME - 1) begin
                    snap_bcd = bcd_in;
                    snap_dp  = dp_in;
                    snap_lz  = blank_lz;
                end
                n_cyc++;
            end
        end
    end

    // Monitor: compares the DUT against the oldest expectation 1 time unit
    // after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (grst) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL queue_empty at %0t: got 0 entries, expected 1", $time);
                end else begin
                    check_output(exp_q.pop_front());
                end
            end
        end
    end

    // Drive a set of inputs at a falling edge and hold them for n cycles.
    task automatic apply_stimulus(input logic [15:0] bcd, input logic [3:0] dpv,
                                  input logic lz, input logic en, input int n);
        @(negedge clk);
        bcd_in   = bcd;
        dp_in    = dpv;
        blank_lz = lz;
        disp_en  = en;
        repeat (n - 1) @(negedge clk);
    endtask

    // Assert reset while a digit is lit and confirm the anodes go dark
    // before the next clock edge, then release after a few cycles.
    task automatic mid_slot_reset();
        int guard = 0;
        disp_en = 1'b1;
        @(negedge clk);
        while (!(n_cyc > 0 && ((n_cyc - 1) % RD) >= BC) && guard < 4 * RD) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (an === 4'b1111) begin
            fails++;
            $display("[TB] FAIL pre_reset_lit at %0t: got an=%b, expected a lit anode", $time, an);
        end
        grst = 1'b0;
        #1;
        check_reset_state();
        repeat (3) @(negedge clk);
        check_reset_state();
        grst = 1'b1;
    endtask

    initial begin
        font[0]  = 7'b1000000; font[1]  = 7'b1111001;
        font[2]  = 7'b0100100; font[3]  = 7'b0110000;
        font[4]  = 7'b0011001; font[5]  = 7'b0010010;
        font[6]  = 7'b0000010; font[7]  = 7'b1111000;
        font[8]  = 7'b0000000; font[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) font[i] = 7'b0111111;

        // Reset held through several edges.
        repeat (3) @(negedge clk);
        check_reset_state();
        grst = 1'b1;

        // Initial zero frame, then 1234 scanned for two frames.
        bcd_in = 16'h1234;
        repeat (3 * FRAME - 1) @(negedge clk);

        // Change the value mid-frame, in slot 1.
        apply_stimulus(16'h1234, 4'b0000, 1'b0, 1'b1, RD + RD / 2);
        apply_stimulus(16'h5678, 4'b0000, 1'b0, 1'b1, 2 * FRAME);

        // Leading-zero blanking and the dash code.
        apply_stimulus(16'h0050, 4'b0000, 1'b1, 1'b1, 2 * FRAME);
        apply_stimulus(16'h00A0, 4'b0000, 1'b1, 1'b1, 2 * FRAME);
        apply_stimulus(16'h0000, 4'b0000, 1'b1, 1'b1, 2 * FRAME);

        // Decimal point on digit 2, then display disabled for a frame.
        apply_stimulus(16'h9876, 4'b0100, 1'b0, 1'b1, 2 * FRAME);
        apply_stimulus(16'h9876, 4'b0100, 1'b0, 1'b0, FRAME);
        apply_stimulus(16'h9876, 4'b0100, 1'b0, 1'b1, FRAME);

        // Asynchronous reset in the middle of a lit slot.
        mid_slot_reset();
        apply_stimulus(16'h4321, 4'b0001, 1'b0, 1'b1, 2 * FRAME);

        // Randomized traffic, including non-BCD nibbles and display toggling.
        for (int i = 0; i < 30; i++) begin
            logic [15:0] r_bcd;
            logic [15:0] mask;
            r_bcd = 16'($urandom);
            mask  = 16'hFFFF >> (4 * $urandom_range(0, 3));
            apply_stimulus(r_bcd & mask, 4'($urandom), 1'($urandom),
                           ($urandom_range(0, 3) != 0), $urandom_range(5, 70));
            if (i == 15) mid_slot_reset();
        end

        apply_stimulus(16'h2468, 4'b1000, 1'b1, 1'b1, 2 * FRAME);

        // Every expectation must have been consumed.
        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
